// File: rtl/hex_rec_pkg.sv
// Shared encodings for the Intel-HEX record parser:
// parser states, ASCII constants, record types, counter load codes.
package hex_rec_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_ADR0,
    S_ADR1,
    S_ADR2,
    S_ADR3,
    S_TYP_H,
    S_TYP_L,
    S_DAT_H,
    S_DAT_L,
    S_CHK_H,
    S_CHK_L
  } state_t;

  localparam logic [7:0] C_COLON = 8'h3A;
  localparam logic [7:0] C_ZERO  = 8'h30;
  localparam logic [7:0] C_UA    = 8'h41;
  localparam logic [7:0] C_LA    = 8'h61;

  localparam logic [7:0] T_DATA = 8'h00;
  localparam logic [7:0] T_EOF  = 8'h01;

  localparam logic [1:0] CLE_NONE = 2'b00;
  localparam logic [1:0] CLE_LO   = 2'b01;
  localparam logic [1:0] CLE_HI   = 2'b10;

endpackage

// File: rtl/hex_nib_dec.sv
// ASCII hex digit decoder: 0-9, A-F, a-f to a nibble.
// Pure combinational; is_hex low for any other character.
module hex_nib_dec
  import hex_rec_pkg::*;
(
  input  logic [7:0] chr,
  output logic [3:0] nib,
  output logic       is_hex
);

  logic [7:0] d0;
  logic [7:0] du;
  logic [7:0] dl;

  // Wrapping subtraction turns each range test into one compare.
  assign d0 = chr - C_ZERO;
  assign du = chr - C_UA;
  assign dl = chr - C_LA;

  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    unique case (1'b1)
      (d0 < 8'd10): begin
        nib    = d0[3:0];
        is_hex = 1'b1;
      end
      (du < 8'd6): begin
        nib    = du[3:0] + 4'd10;
        is_hex = 1'b1;
      end
      (dl < 8'd6): begin
        nib    = dl[3:0] + 4'd10;
        is_hex = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hex_rec_ctrl.sv
// Intel-HEX record parser driving an external byte-count down-counter.
// Define HEX_CHECKSUM_EN to verify the record checksum at CHK_L.
module hex_rec_ctrl
  import hex_rec_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic [7:0]  CHR,
  input  logic        CHR_VLD,
  output logic        CHR_RDY,
  output logic        CNT_CE,
  output logic [1:0]  CNT_CLE,
  output logic [3:0]  CNT_D,
  input  logic        CNT_ZD,
  output logic [7:0]  DOUT,
  output logic [15:0] DOUT_ADDR,
  output logic        DOUT_VLD,
  output logic        REC_OK,
  output logic        EOF,
  output logic        ERR
);

  state_t      st;
  logic [3:0]  nib;
  logic [3:0]  hi;
  logic        is_hex;
  logic        acc;
  logic        bubble;
  logic        bad;
  logic        sum_ok;
  logic [7:0]  byt;
  logic [15:0] addr;
  logic [7:0]  typ;

  hex_nib_dec u_dec (
    .chr    (CHR),
    .nib    (nib),
    .is_hex (is_hex)
  );

  assign bubble  = (st == S_DAT_H) && CNT_ZD;
  assign CHR_RDY = !CLR && !bubble;
  assign acc     = CHR_VLD && CHR_RDY;
  assign byt     = {hi, nib};
  assign bad     = !is_hex ||
                   ((st == S_CNT_H) && (nib > 4'd3));

`ifdef HEX_CHECKSUM_EN
  logic [7:0] csum;
  assign sum_ok = ((csum + byt) == 8'h00);
`else
  assign sum_ok = 1'b1;
`endif

  // Counter controls follow the accepted character directly.
  always_comb begin
    CNT_CE  = 1'b0;
    CNT_CLE = CLE_NONE;
    CNT_D   = 4'h0;
    if (acc && !bad) begin
      case (st)
        S_CNT_H: begin
          CNT_CLE = CLE_HI;
          CNT_D   = nib;
        end
        S_CNT_L: begin
          CNT_CLE = CLE_LO;
          CNT_D   = nib;
        end
        S_DAT_L: CNT_CE = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st        <= S_IDLE;
      hi        <= 4'h0;
      addr      <= 16'h0000;
      typ       <= 8'h00;
      DOUT      <= 8'h00;
      DOUT_ADDR <= 16'h0000;
      DOUT_VLD  <= 1'b0;
      REC_OK    <= 1'b0;
      EOF       <= 1'b0;
      ERR       <= 1'b0;
`ifdef HEX_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      DOUT_VLD <= 1'b0;
      REC_OK   <= 1'b0;
      EOF      <= 1'b0;
      ERR      <= 1'b0;
      if (bubble) begin
        st <= S_CHK_H;
      end else if (acc) begin
        if (st == S_IDLE) begin
          if (CHR == C_COLON) begin
            st <= S_CNT_H;
`ifdef HEX_CHECKSUM_EN
            csum <= 8'h00;
`endif
          end
        end else if (bad) begin
          ERR <= 1'b1;
          st  <= S_IDLE;
        end else begin
          hi <= nib;
          case (st)
            S_CNT_H: st <= S_CNT_L;
            S_CNT_L: st <= S_ADR0;
            S_ADR0, S_ADR1, S_ADR2: begin
              addr <= {addr[11:0], nib};
              st   <= state_t'(st + 4'd1);
            end
            S_ADR3: begin
              addr <= {addr[11:0], nib};
              st   <= S_TYP_H;
            end
            S_TYP_H: begin
              typ <= {typ[3:0], nib};
              st  <= S_TYP_L;
            end
            S_TYP_L: begin
              typ <= {typ[3:0], nib};
              st  <= S_DAT_H;
            end
            S_DAT_H: st <= S_DAT_L;
            S_DAT_L: begin
              DOUT      <= byt;
              DOUT_ADDR <= addr;
              DOUT_VLD  <= (typ == T_DATA);
              addr      <= addr + 16'd1;
              st        <= S_DAT_H;
            end
            S_CHK_H: st <= S_CHK_L;
            S_CHK_L: begin
              if (sum_ok) begin
                REC_OK <= 1'b1;
                EOF    <= (typ == T_EOF);
              end else begin
                ERR <= 1'b1;
              end
              st <= S_IDLE;
            end
            default: st <= S_IDLE;
          endcase
`ifdef HEX_CHECKSUM_EN
          // Low-nibble states complete a byte of the record.
          if (st inside {S_CNT_L, S_ADR1, S_ADR3,
                         S_TYP_L, S_DAT_L})
            csum <= csum + byt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_rec_ctrl.sv
// Scoreboard bench for hex_rec_ctrl: directed records plus random
// records built from byte lists, with an external 6-bit counter model.
module tb_hex_rec_ctrl;

  logic        CLK;
  logic        CLR;
  logic [7:0]  CHR;
  logic        CHR_VLD;
  logic        CHR_RDY;
  logic        CNT_CE;
  logic [1:0]  CNT_CLE;
  logic [3:0]  CNT_D;
  logic        CNT_ZD;
  logic [7:0]  DOUT;
  logic [15:0] DOUT_ADDR;
  logic        DOUT_VLD;
  logic        REC_OK;
  logic        EOF;
  logic        ERR;

  hex_rec_ctrl dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .CHR       (CHR),
    .CHR_VLD   (CHR_VLD),
    .CHR_RDY   (CHR_RDY),
    .CNT_CE    (CNT_CE),
    .CNT_CLE   (CNT_CLE),
    .CNT_D     (CNT_D),
    .CNT_ZD    (CNT_ZD),
    .DOUT      (DOUT),
    .DOUT_ADDR (DOUT_ADDR),
    .DOUT_VLD  (DOUT_VLD),
    .REC_OK    (REC_OK),
    .EOF       (EOF),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [25:0] EV_OK  = {2'd1, 24'd0};
  localparam logic [25:0] EV_EOF = {2'd2, 24'd0};
  localparam logic [25:0] EV_ERR = {2'd3, 24'd0};

  int total = 0;
  int bad   = 0;
  int ce_seen = 0;
  int ce_exp  = 0;
  int stalls  = 0;
  bit gaps    = 0;

  logic [25:0] expq[$];
  logic [7:0]  sq[$];
  logic [5:0]  cle_log[$];
  logic [5:0]  q;

  assign CNT_ZD = (q == 6'd0);

  // External byte-count down-counter, sharing the parser reset.
  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q <= 6'd0;
    end else begin
      if (CNT_CLE == 2'b10) q[5:4] <= CNT_D[1:0];
      else if (CNT_CLE == 2'b01) q[3:0] <= CNT_D;
      else if (CNT_CE) q <= q - 6'd1;
      if (CNT_CLE != 2'b00) cle_log.push_back({CNT_CLE, CNT_D});
      if (CNT_CE) ce_seen <= ce_seen + 1;
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [25:0] ev_d(logic [7:0] d, logic [15:0] a);
    return {2'd0, a, d};
  endfunction

  function automatic logic [7:0] hx(logic [3:0] n, bit lc);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lc ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  task automatic push_str(string s);
    for (int i = 0; i < s.len(); i++) sq.push_back(s[i]);
  endtask

  // Monitor: any strobe pops one expected event.
  initial begin
    logic [25:0] got;
    logic [25:0] want;
    int          n;
    forever begin
      @(negedge CLK);
      if (!CLR && (DOUT_VLD || REC_OK || EOF || ERR)) begin
        n = int'(DOUT_VLD) + int'(REC_OK) + int'(ERR);
        check("strobe_excl", 32'(n),
              32'(n > 1 ? 1 : (EOF && !REC_OK ? 1 : 0)) - 32'(n > 1 ? 1 : (EOF && !REC_OK ? 1 : 0)) + 32'd1);
        if (DOUT_VLD) got = ev_d(DOUT, DOUT_ADDR);
        else if (REC_OK && EOF) got = EV_EOF;
        else if (REC_OK) got = EV_OK;
        else got = EV_ERR;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL event: got %h want none", got);
        end else begin
          want = expq.pop_front();
          check("event", 32'(got), 32'(want));
        end
      end
    end
  end

  task automatic send_all();
    logic [7:0] c;
    int         n;
    bit         done;
    while (sq.size() > 0) begin
      c = sq.pop_front();
      n = 0;
      done = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
      CHR = c;
      CHR_VLD = 1'b1;
      while (!done) begin
        #4;
        if (CHR_RDY) done = 1;
        else stalls++;
        @(negedge CLK);
        n++;
        if (!done && n > 50) begin
          total++;
          bad++;
          $display("FAIL accept: char %h got stuck want taken", c);
          done = 1;
        end
      end
      CHR_VLD = 1'b0;
    end
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    CHR = 8'h3A;
    CHR_VLD = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_rdy", 32'(CHR_RDY), 32'd0);
    check("rst_data", 32'({DOUT_ADDR, DOUT}), 32'd0);
    check("rst_ctl", 32'({CNT_CE, CNT_CLE, CNT_D,
          DOUT_VLD, REC_OK, EOF, ERR}), 32'd0);
    CHR_VLD = 1'b0;
    CLR = 1'b0;
    #1;
    check("rel_rdy", 32'(CHR_RDY), 32'd1);
    @(negedge CLK);
  endtask

  task automatic add_rec030();
    push_str(":0300300002337A1E");
    expq.push_back(ev_d(8'h02, 16'h0030));
    expq.push_back(ev_d(8'h33, 16'h0031));
    expq.push_back(ev_d(8'h7A, 16'h0032));
    expq.push_back(EV_OK);
    ce_exp += 3;
  endtask

  task automatic gen_random(int r);
    logic [7:0]  rb[$];
    logic [7:0]  rs[$];
    logic [7:0]  ll;
    logic [7:0]  ty;
    logic [7:0]  sum;
    logic [7:0]  bc;
    logic [15:0] a;
    int          inj;
    int          done_b;
    int          sel;
    bit          badck;
    bit          ok;
    string       noise;
    string       badch;
    noise = "\r\n xQ";
    badch = "Gz: @/`g";
    repeat ($urandom_range(0, 3))
      sq.push_back(noise[$urandom_range(0, 4)]);
    ll = 8'($urandom_range(0, 12));
    a  = 16'($urandom);
    sel = $urandom_range(0, 9);
    ty = (sel < 6) ? 8'h00 : (sel < 8) ? 8'h01 : (sel < 9) ? 8'h02 : 8'h04;
    if (r % 8 == 0) begin
      a  = 16'hFFFE;
      ll = 8'd4;
      ty = 8'h00;
    end
    rb.delete();
    rb.push_back(ll);
    rb.push_back(a[15:8]);
    rb.push_back(a[7:0]);
    rb.push_back(ty);
    for (int j = 0; j < ll; j++) rb.push_back(8'($urandom));
    sum = 8'd0;
    foreach (rb[i]) sum += rb[i];
    badck = ($urandom_range(0, 5) == 0);
    rb.push_back(8'(8'd0 - sum) + (badck ? 8'd1 : 8'd0));
    rs.delete();
    rs.push_back(8'h3A);
    foreach (rb[i]) begin
      bc = rb[i];
      rs.push_back(hx(bc[7:4], $urandom_range(0, 1) == 1));
      rs.push_back(hx(bc[3:0], $urandom_range(0, 1) == 1));
    end
    inj = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rs.size() - 1) : 0;
    if (inj > 0) begin
      while (rs.size() > inj) void'(rs.pop_back());
      rs.push_back(badch[$urandom_range(0, 7)]);
      done_b = 0;
      for (int j = 0; j < ll; j++) if (10 + 2 * j < inj) done_b++;
      for (int j = 0; j < done_b; j++)
        if (ty == 8'h00) expq.push_back(ev_d(rb[4 + j], a + 16'(j)));
      ce_exp += done_b;
      expq.push_back(EV_ERR);
    end else begin
      for (int j = 0; j < ll; j++)
        if (ty == 8'h00) expq.push_back(ev_d(rb[4 + j], a + 16'(j)));
      ce_exp += int'(ll);
`ifdef HEX_CHECKSUM_EN
      ok = !badck;
`else
      ok = 1'b1;
`endif
      if (!ok) expq.push_back(EV_ERR);
      else if (ty == 8'h01) expq.push_back(EV_EOF);
      else expq.push_back(EV_OK);
    end
    foreach (rs[i]) sq.push_back(rs[i]);
  endtask

  initial begin
    int ce0;
    CLR = 1'b1;
    CHR = 8'h00;
    CHR_VLD = 1'b0;
    do_reset();

    cle_log.delete();
    ce0 = ce_seen;
    add_rec030();
    send_all();
    repeat (4) @(negedge CLK);
    check("cle_n", 32'(cle_log.size()), 32'd2);
    if (cle_log.size() >= 2) begin
      check("cle_hi", 32'(cle_log[0]), 32'h20);
      check("cle_lo", 32'(cle_log[1]), 32'h13);
    end
    check("ce_030", 32'(ce_seen - ce0), 32'd3);

    stalls = 0;
    push_str(":00000001FF");
    expq.push_back(EV_EOF);
    send_all();
    check("bubble", 32'(stalls), 32'd1);

    push_str(":0300300002337A1F");
    expq.push_back(ev_d(8'h02, 16'h0030));
    expq.push_back(ev_d(8'h33, 16'h0031));
    expq.push_back(ev_d(8'h7A, 16'h0032));
`ifdef HEX_CHECKSUM_EN
    expq.push_back(EV_ERR);
`else
    expq.push_back(EV_OK);
`endif
    ce_exp += 3;
    push_str(":4\r\n:00000001FF");
    expq.push_back(EV_ERR);
    expq.push_back(EV_EOF);
    push_str(":03G");
    expq.push_back(EV_ERR);
    add_rec030();
    send_all();

    push_str(":030030000233");
    expq.push_back(ev_d(8'h02, 16'h0030));
    expq.push_back(ev_d(8'h33, 16'h0031));
    ce_exp += 2;
    send_all();
    repeat (3) @(negedge CLK);
    do_reset();
    repeat (3) @(negedge CLK);
    check("clr_drop", 32'(expq.size()), 32'd0);

    gaps = 1;
    for (int r = 0; r < 40; r++) gen_random(r);
    send_all();
    repeat (20) @(negedge CLK);
    check("leftover", 32'(expq.size()), 32'd0);
    check("ce_total", 32'(ce_seen), 32'(ce_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation got stuck want done");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_rec_ctrl.md
HEX_REC_CTRL -- requirements
Module: hex_rec_ctrl

Interface
REQ-001 SHALL provide: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: CLR  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: CHR  in  8  ASCII character from the record source.
REQ-004 SHALL provide: CHR_VLD  in  1  CHR valid.
REQ-005 SHALL provide: CHR_RDY  out  1  character accepted when CHR_VLD and CHR_RDY are both high on the same edge.
REQ-006 SHALL provide: CNT_CE, CNT_CLE[1:0], CNT_D[3:0]  out  external 6-bit byte-count down-counter controls: CLE=10 loads Q[5:4] from D[1:0]; CLE=01 loads Q[3:0]; CE with CLE=00 decrements.
REQ-007 SHALL provide: CNT_ZD  in  1  counter zero flag.
REQ-008 SHALL provide: DOUT  out  8  decoded data byte; DOUT_ADDR  out  16  its address; DOUT_VLD  out  1  one-cycle strobe.
REQ-009 SHALL provide: REC_OK, EOF, ERR  out  1 each  one-cycle status strobes.

Function
REQ-010 SHALL parse Intel-HEX records ":LLAAAATT{DD}CC" with states IDLE, CNT_H, CNT_L, ADR0-ADR3, TYP_H, TYP_L, DAT_H, DAT_L, CHK_H, CHK_L.
REQ-011 IDLE SHALL consume and discard every character except ':', which moves to CNT_H.
REQ-012 In all non-IDLE states, CHR_RDY SHALL be high except in DAT_H when CNT_ZD=1.
REQ-013 CNT_CLE, CNT_CE and CNT_D SHALL be combinational from state and the accepted character, so the counter updates on the same edge on which the character is accepted.
REQ-014 On an accepted CNT_H digit: digit > 3 -> ERR and go to IDLE; otherwise CNT_CLE=10, CNT_D = digit.
REQ-015 On an accepted CNT_L digit: CNT_CLE=01, CNT_D = digit.
REQ-016 ADR0-ADR3 SHALL assemble the address MSB-first; TYP_H/TYP_L SHALL assemble the record type.
REQ-017 DAT_H with CNT_ZD=1 SHALL move to CHK_H without consuming a character (one bubble cycle); this covers LL=00.
REQ-018 On an accepted DAT_L digit: CNT_CE=1 and DOUT/DOUT_ADDR are registered. DOUT_VLD pulses next cycle only when type=00. The address then increments modulo 2^16.
REQ-019 An accepted non-hex character (0-9, A-F, a-f are hex) in any non-IDLE state SHALL pulse ERR and return to IDLE, including ':'.
REQ-020 The running checksum SHALL be the 8-bit sum of all record bytes including CC; it wraps modulo 256.
REQ-021 After CHK_L: go to IDLE. Pulse REC_OK if the record is good (see REQ-027); additionally pulse EOF if type=01. Types other than 00/01 SHALL produce REC_OK with no DOUT_VLD.
REQ-022 Strobes SHALL be mutually exclusive within a cycle, except EOF with REC_OK.

Reset
REQ-023 CLR SHALL force state IDLE, checksum 0, and address 0.
REQ-024 While CLR is high, all outputs SHALL be 0, CHR_RDY included; CHR_RDY SHALL be 1 in the first cycle after CLR release.
REQ-025 CLR mid-record SHALL abandon the record with no strobes. The counter shares CLR.

Configuration
REQ-026 Macro HEX_CHECKSUM_EN SHALL select checksum checking.
REQ-027 With HEX_CHECKSUM_EN defined: a nonzero sum at CHK_L -> ERR instead of REC_OK/EOF. Without it: the sum is not computed, and CHK digits are hex-checked only.

Structure
REQ-028 Package hex_rec_pkg SHALL hold the state encoding, ASCII constants (':', '0', 'A', 'a'), and record-type constants.
REQ-029 Sub-module hex_nib_dec SHALL be combinational: CHR -> 4-bit nibble plus is_hex flag.

Verification
REQ-030 ":0300300002337A1E" -> CNT_CLE=10/D=0, then 01/D=3; three CNT_CE pulses; DOUT 02@0030, 33@0031, 7A@0032; REC_OK.
REQ-031 ":00000001FF" -> one bubble cycle in DAT_H, no DOUT_VLD, REC_OK+EOF together.
REQ-032 ":0300300002337A1F" -> three DOUT_VLD, then ERR with HEX_CHECKSUM_EN; REC_OK without it.
REQ-033 ":4" -> ERR on the first count digit; the following "\r\n:00000001FF" yields EOF.
REQ-034 ":03G" -> ERR on 'G', back to IDLE; a following valid record parses normally.
REQ-035 CLR pulsed after the second data byte of REQ-030 -> outputs 0, no further DOUT_VLD/REC_OK, CHR_RDY=1 after release.
